alu_rs_scheduler: RTL and testbench
===================================

# alu_rs_scheduler

Four-entry reservation station and issue scheduler in front of the execute stage's single ALU. Accepts renamed ALU operations from dispatch, captures missing source operands from the common data bus (CDB) by tag, and issues the oldest entry with both operands ready to execute over a valid/ready handshake. The out-of-order core builds its ALU issue path from this block; execute consumes the issued fields directly as ALU operands and mux selects.

## Interface
- WORD, 32, operand/immediate width
- ADDR_LEN, 32, PC width
- TAG_LEN, 6, physical/ROB tag width
- ENTRIES, 4, station depth (fixed at 4 for this revision)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- flush  input  1  synchronous clear of all entries (mispredict recovery)
- disp_valid  input  1  dispatch request
- disp_ready  output  1  station can accept this cycle
- disp_alu_func  input  4  ALU function code
- disp_opsel1, disp_opsel2  input  2  operand mux selects, passed through
- disp_src1_rdy, disp_src2_rdy  input  1  source already available
- disp_src1_tag, disp_src2_tag  input  TAG_LEN  producer tag when not ready
- disp_src1_val, disp_src2_val  input  WORD  source value when ready
- disp_imm  input  WORD  immediate
- disp_pc  input  ADDR_LEN  instruction PC
- disp_dst_tag  input  TAG_LEN  destination tag
- cdb_valid  input  1  broadcast valid
- cdb_tag  input  TAG_LEN  broadcast tag
- cdb_value  input  WORD  broadcast result
- iss_valid  output  1  an entry is offered to execute
- iss_ready  input  1  execute accepts this cycle
- iss_alu_func, iss_opsel1, iss_opsel2, iss_rs1_value, iss_rs2_value, iss_imm, iss_pc, iss_dst_tag  output  (widths as dispatch)  issued entry payload
- occupancy  output  3  number of valid entries (0..4)

## Operation
- Entry state: valid, two {rdy, tag, value} source slots, payload, age relation. All valid bits clear on reset and on flush.
- Dispatch: accepted when disp_valid && disp_ready. Written into the lowest-index free entry; entry becomes youngest.
- disp_ready = (occupancy < 4). No credit from a same-cycle issue: full station with iss_valid&&iss_ready still shows disp_ready=0 that cycle.
- Dispatch-time bypass: if a source has rdy=0 and cdb_valid && cdb_tag matches, entry stores rdy=1 with cdb_value. Required; without it the operand is lost.
- Wakeup: each valid entry source with rdy=0 and matching CDB tag sets rdy=1 and captures cdb_value at the clock edge. Both sources of one entry may wake on the same broadcast.
- Select: among valid entries with both sources ready, choose the oldest. Age is strict total order by dispatch sequence; ties impossible.
- Issue: iss_valid = any entry eligible (combinational from registered state, flush forces 0). Payload reflects the selected entry; all iss_* fields drive 0 when iss_valid=0. On iss_valid && iss_ready the selected entry's valid clears at the edge. iss_valid && !iss_ready: nothing changes, same entry stays offered unless an older entry becomes eligible.
- Simultaneous dispatch + issue: both take effect; occupancy unchanged. Freed slot reusable from the next cycle.
- Flush: all entries invalid next cycle; dispatch and issue handshakes in the flush cycle are ignored (disp_ready=0, iss_valid=0 during flush).
- occupancy updates by +1 (dispatch), -1 (issue), 0 (both/neither); flush sets 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed by system): occupancy=0, iss_valid=0, iss_* =0, disp_ready=1.
- Dispatch with both sources ready: earliest iss_valid one cycle after the dispatch edge.
- Wakeup: CDB in cycle N makes the entry eligible in cycle N+1; no same-cycle CDB-to-issue bypass.
- Issue: combinational offer, entry freed at the accepting edge; back-to-back issues one per cycle.
- Reset mid-operation: all entries dropped immediately, outputs to reset values without clock.

## Test plan
- Reset, then dispatch func=4'h0, src1=5, src2=7 both ready, iss_ready=1 -> iss_valid=1 next cycle with iss_rs1_value=5, iss_rs2_value=7; occupancy 1->0.
- Dispatch A (src2 tag 3 not ready) then B (both ready); CDB tag 3 value 9 two cycles later -> B issues first, A issues cycle after CDB with iss_rs2_value=9.
- Dispatch entry waiting on tag 5 in same cycle cdb_valid=1 tag 5 value 0xDEAD -> entry eligible next cycle with operand 0xDEAD.
- Fill 4 entries all ready, hold iss_ready=0 -> disp_ready=0, occupancy=4, oldest held stable; raise iss_ready with disp_valid -> one issue, disp_ready=1 following cycle.
- Four entries waiting on distinct tags, flush asserted -> occupancy=0, iss_valid=0 next cycle; later CDB for those tags produces no issue.
- Assert reset low mid-stream with 3 entries -> occupancy=0, iss_valid=0 asynchronously; after release disp_ready=1.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - four-entry ALU reservation station with oldest-ready issue
//
// Purpose: holds renamed ALU operations from dispatch, captures missing source
// operands from the CDB by tag, and offers the oldest fully-ready entry to the
// single ALU over a valid/ready handshake.
//
// Ports:
//   clk, reset (async, active-low), flush (sync clear of all entries)
//   disp_*      dispatch request, payload and source status; disp_ready back-pressure
//   cdb_*       result broadcast used for operand wakeup
//   iss_*       issued entry payload, iss_valid/iss_ready handshake (zeros when idle)
//   occupancy   number of valid entries (0..4)
module alu_rs_scheduler #(
    parameter int WORD     = 32,
    parameter int ADDR_LEN = 32,
    parameter int TAG_LEN  = 6,
    parameter int ENTRIES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,

    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [3:0]          disp_alu_func,
    input  logic [1:0]          disp_opsel1,
    input  logic [1:0]          disp_opsel2,
    input  logic                disp_src1_rdy,
    input  logic                disp_src2_rdy,
    input  logic [TAG_LEN-1:0]  disp_src1_tag,
    input  logic [TAG_LEN-1:0]  disp_src2_tag,
    input  logic [WORD-1:0]     disp_src1_val,
    input  logic [WORD-1:0]     disp_src2_val,
    input  logic [WORD-1:0]     disp_imm,
    input  logic [ADDR_LEN-1:0] disp_pc,
    input  logic [TAG_LEN-1:0]  disp_dst_tag,

    input  logic                cdb_valid,
    input  logic [TAG_LEN-1:0]  cdb_tag,
    input  logic [WORD-1:0]     cdb_value,

    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [3:0]          iss_alu_func,
    output logic [1:0]          iss_opsel1,
    output logic [1:0]          iss_opsel2,
    output logic [WORD-1:0]     iss_rs1_value,
    output logic [WORD-1:0]     iss_rs2_value,
    output logic [WORD-1:0]     iss_imm,
    output logic [ADDR_LEN-1:0] iss_pc,
    output logic [TAG_LEN-1:0]  iss_dst_tag,
    output logic [2:0]          occupancy
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]  valid;
    logic [ENTRIES-1:0]  s1_rdy;
    logic [ENTRIES-1:0]  s2_rdy;
    logic [TAG_LEN-1:0]  s1_tag   [ENTRIES];
    logic [TAG_LEN-1:0]  s2_tag   [ENTRIES];
    logic [WORD-1:0]     s1_val   [ENTRIES];
    logic [WORD-1:0]     s2_val   [ENTRIES];
    logic [3:0]          e_func   [ENTRIES];
    logic [1:0]          e_opsel1 [ENTRIES];
    logic [1:0]          e_opsel2 [ENTRIES];
    logic [WORD-1:0]     e_imm    [ENTRIES];
    logic [ADDR_LEN-1:0] e_pc     [ENTRIES];
    logic [TAG_LEN-1:0]  e_dst    [ENTRIES];
    // older[i][j] = 1 when entry i was dispatched before entry j. Only rows and
    // columns of valid entries are meaningful; stale bits of free slots are
    // masked by the eligibility vector.
    logic [ENTRIES-1:0]  older    [ENTRIES];

    logic [ENTRIES-1:0]  eligible;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                disp_fire;
    logic                iss_fire;
    logic                byp1;
    logic                byp2;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occupancy = occupancy + 3'(valid[i]);
        end
    end

    // Oldest eligible: the entry that no other eligible entry is older than.
    always_comb begin
        eligible  = valid & s1_rdy & s2_rdy;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            logic beaten;
            beaten = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && eligible[j] && older[j][i]) begin
                    beaten = 1'b1;
                end
            end
            if (eligible[i] && !beaten && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot, taken from registered state so a slot freed by
    // this cycle's issue only becomes reusable next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_ready = free_found && !flush;
    assign iss_valid  = sel_found && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_fire   = iss_valid && iss_ready;

    // Dispatch-time bypass: a result broadcast in the dispatch cycle would
    // otherwise be missed by an entry that does not exist yet.
    assign byp1 = !disp_src1_rdy && cdb_valid && (cdb_tag == disp_src1_tag);
    assign byp2 = !disp_src2_rdy && cdb_valid && (cdb_tag == disp_src2_tag);

    always_comb begin
        iss_alu_func  = '0;
        iss_opsel1    = '0;
        iss_opsel2    = '0;
        iss_rs1_value = '0;
        iss_rs2_value = '0;
        iss_imm       = '0;
        iss_pc        = '0;
        iss_dst_tag   = '0;
        if (iss_valid) begin
            iss_alu_func  = e_func[sel_idx];
            iss_opsel1    = e_opsel1[sel_idx];
            iss_opsel2    = e_opsel2[sel_idx];
            iss_rs1_value = s1_val[sel_idx];
            iss_rs2_value = s2_val[sel_idx];
            iss_imm       = e_imm[sel_idx];
            iss_pc        = e_pc[sel_idx];
            iss_dst_tag   = e_dst[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                s1_tag[i]   <= '0;
                s2_tag[i]   <= '0;
                s1_val[i]   <= '0;
                s2_val[i]   <= '0;
                e_func[i]   <= '0;
                e_opsel1[i] <= '0;
                e_opsel2[i] <= '0;
                e_imm[i]    <= '0;
                e_pc[i]     <= '0;
                e_dst[i]    <= '0;
                older[i]    <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid[i] && !s1_rdy[i] && cdb_valid && (cdb_tag == s1_tag[i])) begin
                    s1_rdy[i] <= 1'b1;
                    s1_val[i] <= cdb_value;
                end
                if (valid[i] && !s2_rdy[i] && cdb_valid && (cdb_tag == s2_tag[i])) begin
                    s2_rdy[i] <= 1'b1;
                    s2_val[i] <= cdb_value;
                end
            end
            if (iss_fire) begin
                valid[sel_idx] <= 1'b0;
            end
            // The dispatch slot is free, so it never collides with the issued
            // entry or with a wakeup (wakeup is gated by valid).
            if (disp_fire) begin
                valid[free_idx]    <= 1'b1;
                s1_rdy[free_idx]   <= disp_src1_rdy || byp1;
                s2_rdy[free_idx]   <= disp_src2_rdy || byp2;
                s1_tag[free_idx]   <= disp_src1_tag;
                s2_tag[free_idx]   <= disp_src2_tag;
                s1_val[free_idx]   <= byp1 ? cdb_value : disp_src1_val;
                s2_val[free_idx]   <= byp2 ? cdb_value : disp_src2_val;
                e_func[free_idx]   <= disp_alu_func;
                e_opsel1[free_idx] <= disp_opsel1;
                e_opsel2[free_idx] <= disp_opsel2;
                e_imm[free_idx]    <= disp_imm;
                e_pc[free_idx]     <= disp_pc;
                e_dst[free_idx]    <= disp_dst_tag;
                older[free_idx]    <= '0;
                for (int j = 0; j < ENTRIES; j++) begin
                    if (j != int'(free_idx)) begin
                        older[j][free_idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb/tb_alu_rs_scheduler.sv - directed self-checking bench for alu_rs_scheduler
module tb_alu_rs_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_alu_func;
    logic [1:0]  disp_opsel1;
    logic [1:0]  disp_opsel2;
    logic        disp_src1_rdy;
    logic        disp_src2_rdy;
    logic [5:0]  disp_src1_tag;
    logic [5:0]  disp_src2_tag;
    logic [31:0] disp_src1_val;
    logic [31:0] disp_src2_val;
    logic [31:0] disp_imm;
    logic [31:0] disp_pc;
    logic [5:0]  disp_dst_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_alu_func;
    logic [1:0]  iss_opsel1;
    logic [1:0]  iss_opsel2;
    logic [31:0] iss_rs1_value;
    logic [31:0] iss_rs2_value;
    logic [31:0] iss_imm;
    logic [31:0] iss_pc;
    logic [5:0]  iss_dst_tag;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_rs_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_alu_func (disp_alu_func),
        .disp_opsel1   (disp_opsel1),
        .disp_opsel2   (disp_opsel2),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_val (disp_src1_val),
        .disp_src2_val (disp_src2_val),
        .disp_imm      (disp_imm),
        .disp_pc       (disp_pc),
        .disp_dst_tag  (disp_dst_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_alu_func  (iss_alu_func),
        .iss_opsel1    (iss_opsel1),
        .iss_opsel2    (iss_opsel2),
        .iss_rs1_value (iss_rs1_value),
        .iss_rs2_value (iss_rs2_value),
        .iss_imm       (iss_imm),
        .iss_pc        (iss_pc),
        .iss_dst_tag   (iss_dst_tag),
        .occupancy     (occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [3:0] func,
                            input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                            input logic [5:0] dst);
        disp_valid    = 1'b1;
        disp_alu_func = func;
        disp_opsel1   = 2'd1;
        disp_opsel2   = 2'd2;
        disp_src1_rdy = r1;
        disp_src1_tag = t1;
        disp_src1_val = v1;
        disp_src2_rdy = r2;
        disp_src2_tag = t2;
        disp_src2_val = v2;
        disp_imm      = 32'h100 + 32'(dst);
        disp_pc       = 32'h4000 + 32'(dst);
        disp_dst_tag  = dst;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        set_disp(4'h0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd0);
        disp_valid = 1'b0;
        #2;
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
        n_checks++; if (iss_rs1_value !== 32'd0 || iss_dst_tag !== 6'd0) begin n_fail++; $display("FAIL reset_payload: got %h/%h want 0/0", iss_rs1_value, iss_dst_tag); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        iss_ready = 1'b1;
        set_disp(4'h0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd10);
        step();
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL basic_occ1: got %0d want 1", occupancy); end
        n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL basic_iss_valid: got %b want 1", iss_valid); end
        n_checks++; if (iss_rs1_value !== 32'd5 || iss_rs2_value !== 32'd7) begin n_fail++; $display("FAIL basic_operands: got %0d/%0d want 5/7", iss_rs1_value, iss_rs2_value); end
        n_checks++; if (iss_dst_tag !== 6'd10 || iss_pc !== 32'h400A || iss_imm !== 32'h10A || iss_alu_func !== 4'h0 || iss_opsel1 !== 2'd1 || iss_opsel2 !== 2'd2) begin
            n_fail++; $display("FAIL basic_payload: got dst %0d pc %h imm %h want 10 400a 10a", iss_dst_tag, iss_pc, iss_imm); end
        step();
        n_checks++; if (occupancy !== 3'd0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got occ %0d iv %b want 0 0", occupancy, iss_valid); end
    endtask

    task automatic test_wakeup_order();
        iss_ready = 1'b0;
        set_disp(4'h2, 1'b1, 6'd0, 32'd1, 1'b0, 6'd3, 32'd0, 6'd11);
        step();
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL order_a_waiting: got %b want 0", iss_valid); end
        set_disp(4'h3, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd4, 6'd12);
        step();
        disp_valid = 1'b0;
        n_checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd12) begin n_fail++; $display("FAIL order_b_first: got iv %b dst %0d want 1 12", iss_valid, iss_dst_tag); end
        iss_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_value = 32'd9;
        #1;
        n_checks++; if (iss_dst_tag !== 6'd12) begin n_fail++; $display("FAIL order_no_cdb_bypass: got dst %0d want 12", iss_dst_tag); end
        step();
        cdb_valid = 1'b0;
        n_checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd11 || iss_rs2_value !== 32'd9 || iss_rs1_value !== 32'd1) begin
            n_fail++; $display("FAIL order_a_woken: got iv %b dst %0d rs2 %0d want 1 11 9", iss_valid, iss_dst_tag, iss_rs2_value); end
        step();
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL order_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_dispatch_bypass();
        iss_ready = 1'b0;
        set_disp(4'h1, 1'b1, 6'd0, 32'd1, 1'b0, 6'd5, 32'd0, 6'd13);
        cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_value = 32'hDEAD;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        n_checks++; if (iss_valid !== 1'b1 || iss_rs2_value !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_capture: got iv %b rs2 %h want 1 dead", iss_valid, iss_rs2_value); end
        iss_ready = 1'b1;
        step();
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL bypass_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_back_to_back();
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(4'h4, 1'b1, 6'd0, 32'(20 + i), 1'b1, 6'd0, 32'd0, 6'(20 + i));
            step();
        end
        n_checks++; if (occupancy !== 3'd4 || disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got occ %0d dr %b want 4 0", occupancy, disp_ready); end
        set_disp(4'h4, 1'b1, 6'd0, 32'd30, 1'b1, 6'd0, 32'd0, 6'd30);
        step();
        n_checks++; if (occupancy !== 3'd4 || iss_dst_tag !== 6'd20 || iss_rs1_value !== 32'd20) begin n_fail++; $display("FAIL full_hold: got occ %0d dst %0d want 4 20", occupancy, iss_dst_tag); end
        iss_ready = 1'b1;
        #1;
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_credit: got %b want 0", disp_ready); end
        step();
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 3'd3 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_issue: got occ %0d dr %b want 3 1", occupancy, disp_ready); end
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'(20 + k)) begin n_fail++; $display("FAIL b2b_order%0d: got iv %b dst %0d want 1 %0d", k, iss_valid, iss_dst_tag, 20 + k); end
            step();
        end
        n_checks++; if (occupancy !== 3'd0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got occ %0d iv %b want 0 0", occupancy, iss_valid); end
    endtask

    task automatic test_flush();
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_disp(4'h5, 1'b0, 6'(40 + i), 32'd0, 1'b1, 6'd0, 32'd1, 6'(50 + i));
            step();
        end
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 3'd4 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pre: got occ %0d iv %b want 4 0", occupancy, iss_valid); end
        flush = 1'b1;
        set_disp(4'h5, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 6'd60);
        #1;
        n_checks++; if (disp_ready !== 1'b0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got dr %b iv %b want 0 0", disp_ready, iss_valid); end
        step();
        flush = 1'b0; disp_valid = 1'b0;
        n_checks++; if (occupancy !== 3'd0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post: got occ %0d iv %b want 0 0", occupancy, iss_valid); end
        for (int i = 0; i < 4; i++) begin
            cdb_valid = 1'b1; cdb_tag = 6'(40 + i); cdb_value = 32'd77;
            step();
            n_checks++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_stale_cdb%0d: got iv %b occ %0d want 0 0", i, iss_valid, occupancy); end
        end
        cdb_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(4'h6, 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i), 6'(i + 1));
            step();
        end
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 3'd3 || iss_dst_tag !== 6'd1) begin n_fail++; $display("FAIL areset_pre: got occ %0d dst %0d want 3 1", occupancy, iss_dst_tag); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (occupancy !== 3'd0 || iss_valid !== 1'b0 || iss_dst_tag !== 6'd0) begin n_fail++; $display("FAIL areset_async: got occ %0d iv %b dst %0d want 0 0 0", occupancy, iss_valid, iss_dst_tag); end
        step();
        reset = 1'b1;
        step();
        n_checks++; if (disp_ready !== 1'b1 || occupancy !== 3'd0) begin n_fail++; $display("FAIL areset_release: got dr %b occ %0d want 1 0", disp_ready, occupancy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup_order();
        test_dispatch_bypass();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
